// File: rtl/cpu_control_fsm.sv
// Multi-cycle control unit for the 16-opcode RISC core.
// It sequences FETCH -> EXECUTE (-> MEM_WAIT) -> FETCH. It also handles
// run/single-step gating, a RAM wait-state handshake with timeout,
// an illegal-opcode trap and a HALT state that reports the fault cause.
// The control outputs are decoded combinationally from the state, the opcode
// and the handshake inputs. Only the state, the wait counter and the fault
// code are held in registers.
module cpu_control_fsm #(
  parameter int OPCODE_WIDTH = 4,
  parameter int RD_WIDTH     = 4,
  parameter int FS_WIDTH     = 3,
  parameter int MEM_TIMEOUT  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic [RD_WIDTH-1:0]     rd,
  input  logic                    run,
  input  logic                    step_mode,
  input  logic                    step,
  input  logic                    resume,
  input  logic                    mem_ready,
  output logic [FS_WIDTH-1:0]     fs,
  output logic [1:0]              ps,
  output logic                    mb,
  output logic [1:0]              result_source,
  output logic                    rw,
  output logic                    mw,
  output logic                    bc,
  output logic                    il,
  output logic                    mem_req,
  output logic                    halted,
  output logic [1:0]              fault_code,
  output logic [1:0]              state_o
);

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    EXECUTE  = 2'd1,
    MEM_WAIT = 2'd2,
    HALT     = 2'd3
  } state_t;

  localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = (MEM_TIMEOUT < 1) ? '0 : WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = '1;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;

  logic       advance;
  logic       illegal;
  logic [3:0] op4;
  logic       is_mem;
  logic       is_eoe;
  logic       timeout_hit;

  // Shared decode terms used by both the state register and the output decoder
  always_comb begin
    advance     = run && (!step_mode || step);
    illegal     = (32'(opcode) > 32'd15);
    op4         = opcode[3:0];
    is_mem      = !illegal && ((op4 == 4'd9) || (op4 == 4'd10));
    is_eoe      = !illegal && (op4 == 4'd15) && (rd != '0);
    timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt == WAIT_LAST);
  end

  // State, wait-state counter and fault code; mem_ready beats the timeout
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FETCH;
      wait_cnt   <= '0;
      fault_code <= 2'd0;
    end else begin
      case (state)
        FETCH: begin
          if (advance) state <= EXECUTE;
        end
        EXECUTE: begin
          wait_cnt <= '0;
          if (illegal) begin
            state      <= HALT;
            fault_code <= 2'd1;
          end else if (is_eoe) begin
            state      <= HALT;
            fault_code <= 2'd0;
          end else if (is_mem && !mem_ready) begin
            state <= MEM_WAIT;
          end else begin
            state <= FETCH;
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            state    <= FETCH;
            wait_cnt <= '0;
          end else if (timeout_hit) begin
            state      <= HALT;
            fault_code <= 2'd2;
          end else if (wait_cnt != WAIT_MAX) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        HALT: begin
          if (resume && (fault_code == 2'd0)) state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

  // Control outputs decoded from state and instruction; every output idles at 0
  always_comb begin
    fs            = '0;
    ps            = 2'd0;
    mb            = 1'b0;
    result_source = 2'd0;
    rw            = 1'b0;
    mw            = 1'b0;
    bc            = 1'b0;
    il            = 1'b0;
    mem_req       = 1'b0;
    case (state)
      FETCH: begin
        if (advance) il = 1'b1;
      end
      EXECUTE: begin
        if (!illegal) begin
          case (op4) inside
            [4'd0:4'd7]: begin
              fs = FS_WIDTH'(op4[2:0]);
              rw = 1'b1;
              ps = 2'd1;
            end
            4'd8: begin
              mb            = 1'b1;
              result_source = 2'd1;
              rw            = 1'b1;
              ps            = 2'd1;
            end
            4'd9, 4'd10: begin
              mem_req = 1'b1;
              if (mem_ready) begin
                ps = 2'd1;
                if (op4 == 4'd9) begin
                  result_source = 2'd2;
                  rw            = 1'b1;
                end else begin
                  mw = 1'b1;
                end
              end
            end
            4'd11: ps = 2'd2;
            4'd12: begin
              ps = 2'd2;
              bc = 1'b1;
            end
            4'd13: begin
              ps            = 2'd3;
              result_source = 2'd3;
              rw            = 1'b1;
            end
            4'd14: ps = 2'd2;
            default: begin
              if (rd == '0) ps = 2'd2;
            end
          endcase
        end
      end
      MEM_WAIT: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ps = 2'd1;
          if (op4 == 4'd9) begin
            result_source = 2'd2;
            rw            = 1'b1;
          end else begin
            mw = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign halted  = (state == HALT);
  assign state_o = state;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed bench for cpu_control_fsm built with a 5-bit opcode and a 4-cycle memory timeout.
// Inputs change just after the falling edge. Outputs are checked 1 ns later.
// Each check compares one packed word that holds every output.
module tb_cpu_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] opcode;
  logic [3:0] rd;
  logic       run, step_mode, step, resume, mem_ready;
  logic [2:0] fs;
  logic [1:0] ps, result_source, fault_code, state_o;
  logic       mb, rw, mw, bc, il, mem_req, halted;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [1:0] S_F = 2'd0, S_E = 2'd1, S_W = 2'd2, S_H = 2'd3;

  cpu_control_fsm #(
    .OPCODE_WIDTH(5), .RD_WIDTH(4), .FS_WIDTH(3), .MEM_TIMEOUT(4)
  ) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .rd(rd), .run(run),
    .step_mode(step_mode), .step(step), .resume(resume), .mem_ready(mem_ready),
    .fs(fs), .ps(ps), .mb(mb), .result_source(result_source), .rw(rw), .mw(mw),
    .bc(bc), .il(il), .mem_req(mem_req), .halted(halted),
    .fault_code(fault_code), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Packing order: state, fault, halted, il, mem_req, ps, fs, mb, result_source, rw, mw, bc
  function automatic logic [17:0] vec(input logic [1:0] st, input logic [1:0] fc, input logic h,
                                      input logic i, input logic mr, input logic [1:0] p,
                                      input logic [2:0] f, input logic m, input logic [1:0] rs,
                                      input logic r, input logic w, input logic b);
    return {st, fc, h, i, mr, p, f, m, rs, r, w, b};
  endfunction

  task automatic check_output(input string tag, input logic [17:0] expected);
    logic [17:0] observed;
    #1;
    observed = {state_o, fault_code, halted, il, mem_req, ps, fs, mb, result_source, rw, mw, bc};
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Fetch one instruction under run=1, check the fetch cycle, then drop run
  task automatic fetch_op(input logic [4:0] op, input logic [3:0] r, input string tag);
    opcode = op;
    rd     = r;
    run    = 1'b1;
    check_output(tag, vec(S_F, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc();
    run = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; opcode = '0; rd = '0; run = 1'b0; step_mode = 1'b0;
    step = 1'b0; resume = 1'b0; mem_ready = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
    check_output("reset", vec(S_F, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // ADD: fetch then execute
    fetch_op(5'd0, 4'd0, "add_fetch");
    check_output("add_exec", vec(S_E, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0));
    cyc();
    check_output("add_back", vec(S_F, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // SRA-slot opcode 7 and LI
    fetch_op(5'd7, 4'd0, "op7_fetch");
    check_output("op7_exec", vec(S_E, 0, 0, 0, 0, 1, 3'd7, 0, 0, 1, 0, 0));
    cyc();
    fetch_op(5'd8, 4'd0, "li_fetch");
    check_output("li_exec", vec(S_E, 0, 0, 0, 0, 1, 0, 1, 1, 1, 0, 0));
    cyc();

    // LW with two stalled MEM_WAIT cycles, ready on the third
    mem_ready = 1'b0;
    fetch_op(5'd9, 4'd0, "lw_fetch");
    check_output("lw_exec", vec(S_E, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    cyc();
    check_output("lw_wait0", vec(S_W, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    cyc();
    check_output("lw_wait1", vec(S_W, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    cyc();
    mem_ready = 1'b1;
    check_output("lw_ready", vec(S_W, 0, 0, 0, 1, 1, 0, 0, 2, 1, 0, 0));
    cyc();
    mem_ready = 1'b0;
    check_output("lw_done", vec(S_F, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // SW completing in EXECUTE
    mem_ready = 1'b1;
    fetch_op(5'd10, 4'd0, "sw_fetch");
    check_output("sw_exec_ready", vec(S_E, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0));
    cyc();
    mem_ready = 1'b0;
    check_output("sw_done", vec(S_F, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Branches and jumps
    fetch_op(5'd11, 4'd0, "biz_fetch");
    check_output("biz_exec", vec(S_E, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0));
    cyc();
    fetch_op(5'd12, 4'd0, "bnz_fetch");
    check_output("bnz_exec", vec(S_E, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 1));
    cyc();
    fetch_op(5'd13, 4'd0, "jal_fetch");
    check_output("jal_exec", vec(S_E, 0, 0, 0, 0, 3, 0, 0, 3, 1, 0, 0));
    cyc();
    fetch_op(5'd14, 4'd0, "jmp_fetch");
    check_output("jmp_exec", vec(S_E, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0));
    cyc();
    fetch_op(5'd15, 4'd0, "jr_fetch");
    check_output("jr_exec", vec(S_E, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0));
    cyc();
    check_output("jr_no_halt", vec(S_F, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // SW timeout: four MEM_WAIT cycles, then HALT with fault 2
    fetch_op(5'd10, 4'd0, "swto_fetch");
    check_output("swto_exec", vec(S_E, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++) begin
      cyc();
      check_output($sformatf("swto_wait%0d", i), vec(S_W, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    end
    cyc();
    check_output("swto_halt", vec(S_H, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    resume = 1'b1;
    cyc();
    resume = 1'b0;
    check_output("swto_resume_ignored", vec(S_H, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check_output("swto_reset", vec(S_F, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // EOE halts cleanly; resume returns to FETCH
    fetch_op(5'd15, 4'd3, "eoe_fetch");
    check_output("eoe_exec", vec(S_E, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc();
    check_output("eoe_halt", vec(S_H, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    resume = 1'b1;
    cyc();
    resume = 1'b0;
    check_output("eoe_resume", vec(S_F, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Illegal opcode 20: fault 1, resume ignored, reset recovers
    fetch_op(5'd20, 4'd0, "ill_fetch");
    check_output("ill_exec", vec(S_E, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc();
    check_output("ill_halt", vec(S_H, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    resume = 1'b1;
    cyc();
    resume = 1'b0;
    check_output("ill_resume_ignored", vec(S_H, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check_output("ill_reset", vec(S_F, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Reset in the middle of MEM_WAIT drops mem_req
    fetch_op(5'd9, 4'd0, "rstw_fetch");
    cyc();
    check_output("rstw_wait", vec(S_W, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b1;
    cyc();
    check_output("rstw_after", vec(S_F, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b0;

    // Single-step: no fetch without a pulse, exactly one instruction per pulse
    step_mode = 1'b1;
    run       = 1'b1;
    step      = 1'b0;
    opcode    = 5'd3;
    for (int i = 0; i < 5; i++) begin
      check_output($sformatf("step_idle%0d", i), vec(S_F, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      cyc();
    end
    step = 1'b1;
    check_output("step_fetch", vec(S_F, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc();
    step = 1'b0;
    check_output("step_exec", vec(S_E, 0, 0, 0, 0, 1, 3'd3, 0, 0, 1, 0, 0));
    cyc();
    check_output("step_back", vec(S_F, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc();
    check_output("step_hold", vec(S_F, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
